// File: rtl/exec_writeback_unit_pkg.sv
// exec_writeback_unit_pkg: opcodes, FSM states and default widths shared with the register file.
package exec_writeback_unit_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 4;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;
endpackage

// File: rtl/exec_writeback_unit_mul.sv
// seq_multiplier: shift-add multiplier, one partial product per cycle for W cycles.
module seq_multiplier #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*W-1:0] prod_o
);
  localparam int CW = $clog2(W);
  logic [2*W-1:0] a_q, acc_q;
  logic [W-1:0]   b_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  assign busy_o = busy_q;
  assign done_o = busy_q && (cnt_q == CW'(W-1));
  assign prod_o = acc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      a_q    <= {{W{1'b0}}, a_i};
      b_q    <= b_i;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q  <= b_q[0] ? acc_q + a_q : acc_q;
      a_q    <= a_q << 1;
      b_q    <= b_q >> 1;
      cnt_q  <= cnt_q + CW'(1);
      busy_q <= !done_o;
    end
  end
endmodule

// File: rtl/exec_writeback_unit.sv
// exec_writeback_unit: read two registers, execute ALU/multiply, write the result back.
module exec_writeback_unit
  import exec_writeback_unit_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic [ADDR_W-1:0] dst,
  output logic              busy,
  output logic              done,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic [ADDR_W-1:0] Source1,
  output logic [ADDR_W-1:0] Source2,
  output logic              RegFileRead,
  input  logic [DATA_W-1:0] Dataout1,
  input  logic [DATA_W-1:0] Dataout2,
  output logic              RegFileWrite,
  output logic [ADDR_W-1:0] Destin,
  output logic [DATA_W-1:0] Datain
);
  state_t state_q, state_d;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   src1_q, src2_q, dst_q;
  logic [DATA_W-1:0]   a_q, b_q, alu_q, alu_res, wb_res;
  logic                alu_c_q, alu_c, wb_c, zero_q, carry_q;
  logic                mul_busy, mul_done;
  logic [2*DATA_W-1:0] prod, shl_w, shr_w;
  logic [DATA_W:0]     add_w, sub_w;
  seq_multiplier #(.W(DATA_W)) u_mul (
    .clk     (clk),
    .rst_n   (Reset_n),
    .start_i (state_q == S_READ && op_q == OP_MUL),
    .a_i     (Dataout1),
    .b_i     (Dataout2),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .prod_o  (prod)
  );
  assign add_w = {1'b0, a_q} + {1'b0, b_q};
  assign sub_w = {1'b0, a_q} - {1'b0, b_q};
  // the last bit shifted out lands just across the word boundary
  assign shl_w = {{DATA_W{1'b0}}, a_q} << b_q[2:0];
  assign shr_w = {a_q, {DATA_W{1'b0}}} >> b_q[2:0];
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD: {alu_c, alu_res} = add_w;
      OP_SUB: {alu_c, alu_res} = sub_w;
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SHL: {alu_c, alu_res} = {shl_w[DATA_W], shl_w[DATA_W-1:0]};
      OP_SHR: {alu_c, alu_res} = {shr_w[DATA_W-1], shr_w[2*DATA_W-1:DATA_W]};
      default: ;
    endcase
  end
  assign wb_res = (op_q == OP_MUL) ? prod[DATA_W-1:0] : alu_q;
  assign wb_c   = (op_q == OP_MUL) ? |prod[2*DATA_W-1:DATA_W] : alu_c_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = start ? S_READ : S_IDLE;
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = (op_q == OP_MUL && mul_busy && !mul_done) ? S_EXEC : S_WB;
      S_WB:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      dst_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      alu_c_q <= 1'b0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        op_q   <= op;
        src1_q <= src1;
        src2_q <= src2;
        dst_q  <= dst;
      end
      if (state_q == S_READ) begin
        a_q <= Dataout1;
        b_q <= Dataout2;
      end
      if (state_q == S_EXEC && op_q != OP_MUL) begin
        alu_q   <= alu_res;
        alu_c_q <= alu_c;
      end
      if (state_q == S_WB) begin
        zero_q  <= (wb_res == '0);
        carry_q <= wb_c;
      end
    end
  end
  assign busy         = state_q != S_IDLE;
  assign done         = state_q == S_WB;
  assign RegFileRead  = state_q == S_READ;
  assign RegFileWrite = state_q == S_WB;
  assign Source1      = src1_q;
  assign Source2      = src2_q;
  assign Destin       = dst_q;
  assign Datain       = wb_res;
  assign zero_flag    = zero_q;
  assign carry_flag   = carry_q;
endmodule

// File: tb/tb_exec_writeback_unit.sv
// tb_exec_writeback_unit: directed checks with a behavioural 16x8 register file around the DUT.
module tb_exec_writeback_unit;
  logic       clk = 1'b0;
  logic       Reset_n, start;
  logic [2:0] op;
  logic [3:0] src1, src2, dst, Source1, Source2, Destin;
  logic       busy, done, zero_flag, carry_flag, RegFileRead, RegFileWrite;
  logic [7:0] Dataout1, Dataout2, Datain;
  logic [7:0] rf [16];
  logic       pl_en;
  logic [3:0] pl_addr;
  logic [7:0] pl_data;
  int         wr_cnt = 0;
  int         checks = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  exec_writeback_unit dut (
    .clk(clk), .Reset_n(Reset_n), .start(start), .op(op),
    .src1(src1), .src2(src2), .dst(dst),
    .busy(busy), .done(done), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .Source1(Source1), .Source2(Source2), .RegFileRead(RegFileRead),
    .Dataout1(Dataout1), .Dataout2(Dataout2),
    .RegFileWrite(RegFileWrite), .Destin(Destin), .Datain(Datain)
  );
  assign Dataout1 = rf[Source1];
  assign Dataout2 = rf[Source2];
  always @(posedge clk) begin
    if (RegFileWrite) begin
      rf[Destin] <= Datain;
      wr_cnt     <= wr_cnt + 1;
    end else if (pl_en) begin
      rf[pl_addr] <= pl_data;
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [3:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask
  task automatic run_op(input logic [2:0] o, input logic [3:0] s1, input logic [3:0] s2,
                        input logic [3:0] d, input logic [7:0] er, input logic ec,
                        input int lat, input int poke);
    int n;
    int w0;
    w0 = wr_cnt;
    op = o; src1 = s1; src2 = s2; dst = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    check("read_cycle", 32'({RegFileRead, busy, done}), 32'b110);
    check("sources", 32'({Source1, Source2}), 32'({s1, s2}));
    while (!done && n < 20) begin
      if (n == poke) begin
        start = 1'b1; op = 3'd0; dst = 4'd9;
      end
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    check("latency", 32'(n), 32'(lat));
    check("wb_strobe", 32'({RegFileWrite, busy}), 32'b11);
    check("destin", 32'(Destin), 32'(d));
    check("datain", 32'(Datain), 32'(er));
    @(posedge clk); #1;
    check("flags", 32'({zero_flag, carry_flag}), 32'({er == 8'h00, ec}));
    check("rf_dst", 32'(rf[d]), 32'(er));
    check("idle_after", 32'({busy, done, RegFileWrite}), 32'b0);
    check("one_write", 32'(wr_cnt - w0), 32'd1);
  endtask
  initial begin
    int w0;
    Reset_n = 1'b0; start = 1'b0; op = '0; src1 = '0; src2 = '0; dst = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", 32'({busy, done, RegFileRead, RegFileWrite}), 32'b0);
    check("rst_flags", 32'({zero_flag, carry_flag}), 32'b0);
    check("rst_idx", 32'({Source1, Source2, Destin}), 32'b0);
    check("rst_datain", 32'(Datain), 32'h0);
    Reset_n = 1'b1;
    @(posedge clk); #1;
    load(4'd1, 8'h3C); load(4'd2, 8'h0F);
    run_op(3'd0, 4'd1, 4'd2, 4'd3, 8'h4B, 1'b0, 3, 0);
    load(4'd1, 8'h05); load(4'd2, 8'h07);
    run_op(3'd1, 4'd1, 4'd2, 4'd4, 8'hFE, 1'b1, 3, 0);
    load(4'd1, 8'h07);
    run_op(3'd1, 4'd1, 4'd2, 4'd4, 8'h00, 1'b0, 3, 0);
    load(4'd1, 8'hF0); load(4'd2, 8'h3C);
    run_op(3'd2, 4'd1, 4'd2, 4'd11, 8'h30, 1'b0, 3, 0);
    run_op(3'd3, 4'd1, 4'd2, 4'd12, 8'hFC, 1'b0, 3, 0);
    run_op(3'd4, 4'd1, 4'd2, 4'd13, 8'hCC, 1'b0, 3, 0);
    load(4'd1, 8'hFF); load(4'd2, 8'h01);
    run_op(3'd0, 4'd1, 4'd2, 4'd14, 8'h00, 1'b1, 3, 0);
    load(4'd1, 8'h12); load(4'd2, 8'h0F); load(4'd9, 8'hA5);
    run_op(3'd7, 4'd1, 4'd2, 4'd5, 8'h0E, 1'b1, 10, 4);
    check("ignored_start_dst", 32'(rf[9]), 32'hA5);
    load(4'd1, 8'h03); load(4'd2, 8'h04);
    run_op(3'd7, 4'd1, 4'd2, 4'd6, 8'h0C, 1'b0, 10, 0);
    load(4'd1, 8'h81); load(4'd2, 8'h01);
    run_op(3'd5, 4'd1, 4'd2, 4'd7, 8'h02, 1'b1, 3, 0);
    load(4'd2, 8'h00);
    run_op(3'd6, 4'd1, 4'd2, 4'd8, 8'h81, 1'b0, 3, 0);
    load(4'd2, 8'h01);
    run_op(3'd6, 4'd1, 4'd2, 4'd8, 8'h40, 1'b1, 3, 0);
    // abort a multiply in its fifth cycle; carry is set beforehand so the clear is visible
    load(4'd10, 8'h55);
    w0 = wr_cnt;
    op = 3'd7; src1 = 4'd1; src2 = 4'd1; dst = 4'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mul_in_exec", 32'({busy, RegFileRead, RegFileWrite}), 32'b100);
    Reset_n = 1'b0;
    #1;
    check("abort_ctrl", 32'({busy, done, RegFileWrite, RegFileRead}), 32'b0);
    check("abort_flags", 32'({zero_flag, carry_flag}), 32'b0);
    @(posedge clk); #1;
    Reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_idle", 32'({busy, done}), 32'b0);
    check("abort_no_write", 32'(wr_cnt - w0), 32'd0);
    check("abort_rf_dst", 32'(rf[10]), 32'h55);
    run_op(3'd0, 4'd1, 4'd2, 4'd15, 8'h82, 1'b0, 3, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
